// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/valid handshake with
// variable latency, and drives the IF/ID pipeline register (hold on stall, flush on branch).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            hold_buf_q   <= 32'h0;
            ifid_pc_q    <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (branch_taken) begin
            // Flush beats stall; ifid_pc is deliberately left as-is.
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            pc_d         = {branch_target[31:2], 2'b00};
            unique case (state_q)
                StReq:             state_d = StDiscard;
                StWait, StDiscard: state_d = imem_valid ? StReq : StDiscard;
                StHold:            state_d = StReq;
                default:           state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: state_d = StWait;
                StWait: begin
                    if (imem_valid) begin
                        if (stall) begin
                            hold_buf_d = imem_rdata;
                            state_d    = StHold;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem_rdata;
                            ifid_valid_d = 1'b1;
                            pc_d         = pc_q + 32'd4;
                            state_d      = StReq;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = hold_buf_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = StReq;
                    end
                end
                StDiscard: begin
                    if (imem_valid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end
    end

    assign imem_req   = (state_q == StReq);
    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 32-bit pipelined RISC-V core. It is the producer of the instruction word that the ID-stage control decoder consumes. It owns the PC and issues word reads to instruction memory over a request/valid handshake with variable latency. It loads the IF/ID pipeline register, holds it on hazard stall, and flushes it to a NOP on a taken branch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) placed in IF/ID on reset and on flush.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  from hazard unit; when 1, IF/ID and PC advance are held.
- branch_taken  in  1  one-cycle pulse from EX; redirect fetch and flush IF/ID.
- branch_target  in  32  redirect address; bits [1:0] ignored (forced to 0).
- imem_req  out  1  read request, high for exactly one cycle per request.
- imem_addr  out  32  word address, valid while imem_req=1 (= current pc).
- imem_valid  in  1  read data return; exactly one per request, >=1 cycle after the request.
- imem_rdata  in  32  instruction word, sampled when imem_valid=1.
- ifid_pc  out  32  PC of the instruction held in IF/ID.
- ifid_instr  out  32  instruction word to ID stage (control decoder input).
- ifid_valid  out  1  1 = ifid_instr is a real fetched instruction; 0 = bubble.

## Operation
- Internal regs: pc[31:0], state, hold_buf[31:0] (instruction captured during stall).
- FSM states:
  - REQ: imem_req=1, imem_addr=pc, then go to WAIT.
  - WAIT: request outstanding.
  - HOLD: response captured in hold_buf, waiting for stall to drop.
  - DISCARD: outstanding response belongs to a squashed path.
- WAIT, imem_valid=1, stall=0: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; go to REQ.
- WAIT, imem_valid=1, stall=1: hold_buf <= imem_rdata; go to HOLD. IF/ID is unchanged.
- HOLD, stall=0: IF/ID <= {pc, hold_buf, 1}; pc <= pc+4; go to REQ.
- DISCARD, imem_valid=1: drop the data and go to REQ. pc is not incremented.
- imem_valid is ignored in REQ and HOLD; it must not occur there in a legal system.
- stall=1 with no event above: IF/ID, pc and hold_buf all hold.
- branch_taken=1 has priority over stall and over every other transition:
  - IF/ID <= {ifid_pc unchanged, NOP_INSTR, 0}.
  - pc <= {branch_target[31:2], 2'b00}.
  - In REQ (request issuing this cycle), go to DISCARD.
  - In WAIT or DISCARD with imem_valid=0, go to DISCARD.
  - In WAIT or DISCARD with imem_valid=1, drop the response and go to REQ.
  - In HOLD, drop hold_buf and go to REQ.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: state=REQ, pc=RESET_PC, ifid_pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_valid=0, hold_buf=0.
- imem_req is combinational from state, so it is 1 in the first cycle after reset is released.
- Reset asserted mid-operation aborts any outstanding request. A late imem_valid arriving in REQ is ignored.
- With a 1-cycle memory (REQ in cycle n, imem_valid in n+1), IF/ID updates at the end of n+1 and the next REQ is in cycle n+2.
- Steady-state throughput is therefore 1 instruction per 2 cycles. Each extra memory latency cycle adds one WAIT cycle.
- Branch flush: ifid_valid=0 in the cycle after the branch_taken pulse.
- After a redirect, the first request to the target issues in the cycle after DISCARD ends, or in the next cycle if the FSM went straight to REQ.
- No combinational path from any input to ifid_* outputs; only imem_req and imem_addr depend on state and pc.

## Test plan
- Reset, then 1-cycle memory returning 32'h00A00093, 32'h00B00113:
  - First imem_addr = 0x0, then 0x4.
  - ifid_instr = 32'h00A00093 with ifid_pc = 0x0, then 32'h00B00113 with ifid_pc = 0x4; ifid_valid = 1.
- stall=1 for 3 cycles while the response for 0x8 (32'h002081B3) arrives:
  - IF/ID holds its previous value throughout; FSM enters HOLD.
  - One cycle after stall drops, ifid_instr = 32'h002081B3 and the next imem_addr = 0xC.
- branch_taken with branch_target = 0x40 while WAIT, memory latency 3:
  - Next cycle: ifid_instr = 32'h00000013, ifid_valid = 0.
  - The stale response is dropped.
  - The next imem_addr = 0x40, and the subsequent ifid_pc = 0x40.
- branch_taken with branch_target = 0x103 in the same cycle as stall=1: flush wins, and the next imem_addr = 0x100.
- RESET_PC = 32'hFFFF_FFFC: first fetch at 0xFFFFFFFC, second imem_addr = 0x0.
- Assert reset while WAIT, then deliver a late imem_valid in the first post-reset cycle:
  - The late response is ignored; ifid_valid stays 0.
  - imem_addr = RESET_PC.
